elastic_pipeline: RTL and testbench

ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/pipe_slot.sv | 37 +++
 rtl/elastic_pipeline.sv | 81 ++++++++
 tb/tb_elastic_pipeline.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants and sizing helpers for the elastic register pipeline.
package pipeline_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 3;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One elastic stage: a valid bit plus a payload register that advances whenever
// it is empty or its downstream neighbour can take its current item.
module pipe_slot
    import pipeline_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    assign ready = ~valid | down_ready;

    // Bubbles advance the valid bit only, so the payload of the last real item
    // stays visible on the output while the stage is empty.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipeline.sv
// DEPTH-stage elastic pipeline with combinational ready propagation, flush and
// a live count of occupied stages.
module elastic_pipeline
    import pipeline_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    input  logic                        flush,
    output logic [occ_width(DEPTH)-1:0] occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    // Handshake: an item moves across a boundary on a rising edge where the
    // sender's valid and the receiver's ready are both 1; valid never waits on ready.
    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [OCC_W-1:0] valid_count;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : gen_slot
            logic             up_valid;
            logic [WIDTH-1:0] up_data;
            logic             down_ready;
            logic             ready;

            if (k == 0) begin : g_head
                assign up_valid = in_valid;
                assign up_data  = in_data;
            end else begin : g_body
                assign up_valid = stage_valid[k-1];
                assign up_data  = stage_data[k-1];
            end

            // Ready chains back stage by stage from out_ready.
            if (k == DEPTH - 1) begin : g_tail
                assign down_ready = out_ready;
            end else begin : g_mid
                assign down_ready = gen_slot[k+1].ready;
            end

            pipe_slot #(
                .WIDTH(WIDTH)
            ) u_slot (
                .clock     (clock),
                .reset_n   (reset_n),
                .flush     (flush),
                .up_valid  (up_valid),
                .up_data   (up_data),
                .down_ready(down_ready),
                .ready     (ready),
                .valid     (stage_valid[k]),
                .data      (stage_data[k])
            );
        end
    endgenerate

    always_comb begin
        valid_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_count = valid_count + OCC_W'(stage_valid[i]);
        end
    end

    // While reset is held the outputs already show the post-reset empty state.
    assign in_ready  = (gen_slot[0].ready | ~reset_n) & ~flush;
    assign out_valid = stage_valid[DEPTH-1] & reset_n & ~flush;
    assign out_data  = reset_n ? stage_data[DEPTH-1] : '0;
    assign occupancy = reset_n ? valid_count : '0;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: cycle-exact vector table on a DEPTH=3 instance and
// randomised stall traffic through DEPTH=1 and DEPTH=5 instances.
module tb_elastic_pipeline;

    localparam int N_ITEMS = 1000;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // DEPTH=3 instance, driven from the vector table
    logic       iv3, ir3, ov3, or3, fl3;
    logic [7:0] d3, od3;
    logic [1:0] occ3;

    // DEPTH=1 and DEPTH=5 instances, driven randomly
    logic       iv1, ir1, ov1, or1;
    logic [7:0] d1, od1;
    logic [0:0] occ1;
    logic       iv5, ir5, ov5, or5;
    logic [7:0] d5, od5;
    logic [2:0] occ5;
    logic       no_flush;

    elastic_pipeline #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv3), .in_data(d3), .in_ready(ir3),
        .out_valid(ov3), .out_data(od3), .out_ready(or3), .flush(fl3), .occupancy(occ3)
    );
    elastic_pipeline #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv1), .in_data(d1), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ready(or1), .flush(no_flush), .occupancy(occ1)
    );
    elastic_pipeline #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv5), .in_data(d5), .in_ready(ir5),
        .out_valid(ov5), .out_data(od5), .out_ready(or5), .flush(no_flush), .occupancy(occ5)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       iv;
        logic [7:0] d;
        logic       orr;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_occ;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic iv, input logic [7:0] d, input logic orr,
                       input logic fl, input logic e_ir, input logic e_ov,
                       input logic [7:0] e_od, input logic [1:0] e_occ);
        vec_t v;
        v = '{r, iv, d, orr, fl, e_ir, e_ov, e_od, e_occ};
        tbl.push_back(v);
    endtask

    logic [7:0] exp_q1[$];
    logic [7:0] exp_q5[$];

    initial begin
        int sent1, sent5, recv1, recv5, mocc1, mocc5, cyc;
        logic [7:0] e;
        bit acc1, emit1, acc5, emit5;

        reset_n = 1'b0; no_flush = 1'b0;
        iv3 = 1'b0; d3 = 8'h00; or3 = 1'b0; fl3 = 1'b0;
        iv1 = 1'b0; d1 = 8'h00; or1 = 1'b0;
        iv5 = 1'b0; d5 = 8'h00; or5 = 1'b0;

        // Columns: rst_n iv data or flush | in_ready out_valid out_data occupancy
        // Back-to-back 01..05 with out_ready=1: first out three cycles later.
        add(1, 1, 8'h01, 1, 0, 1, 0, 8'h00, 0);
        add(1, 1, 8'h02, 1, 0, 1, 0, 8'h00, 1);
        add(1, 1, 8'h03, 1, 0, 1, 0, 8'h00, 2);
        add(1, 1, 8'h04, 1, 0, 1, 1, 8'h01, 3);
        add(1, 1, 8'h05, 1, 0, 1, 1, 8'h02, 3);
        add(1, 0, 8'h00, 1, 0, 1, 1, 8'h03, 3);
        add(1, 0, 8'h00, 1, 0, 1, 1, 8'h04, 2);
        add(1, 0, 8'h00, 1, 0, 1, 1, 8'h05, 1);
        add(1, 0, 8'h00, 1, 0, 1, 0, 8'h05, 0);
        // Stall: A0..A2 fill the pipe, A3 waits, then drain in order.
        add(1, 1, 8'hA0, 0, 0, 1, 0, 8'h05, 0);
        add(1, 1, 8'hA1, 0, 0, 1, 0, 8'h05, 1);
        add(1, 1, 8'hA2, 0, 0, 1, 0, 8'h05, 2);
        add(1, 1, 8'hA3, 0, 0, 0, 1, 8'hA0, 3);
        add(1, 1, 8'hA3, 0, 0, 0, 1, 8'hA0, 3);
        add(1, 1, 8'hA3, 1, 0, 1, 1, 8'hA0, 3);
        add(1, 0, 8'h00, 1, 0, 1, 1, 8'hA1, 3);
        add(1, 0, 8'h00, 1, 0, 1, 1, 8'hA2, 2);
        add(1, 0, 8'h00, 1, 0, 1, 1, 8'hA3, 1);
        add(1, 0, 8'h00, 1, 0, 1, 0, 8'hA3, 0);
        // Full pipe streaming: in and out in the same cycle, no gaps.
        add(1, 1, 8'hB0, 0, 0, 1, 0, 8'hA3, 0);
        add(1, 1, 8'hB1, 0, 0, 1, 0, 8'hA3, 1);
        add(1, 1, 8'hB2, 0, 0, 1, 0, 8'hA3, 2);
        add(1, 1, 8'hB3, 1, 0, 1, 1, 8'hB0, 3);
        add(1, 1, 8'hB4, 1, 0, 1, 1, 8'hB1, 3);
        add(1, 1, 8'hB5, 1, 0, 1, 1, 8'hB2, 3);
        add(1, 1, 8'hB6, 1, 0, 1, 1, 8'hB3, 3);
        // Drain to two items, then flush against in_valid/out_ready.
        add(1, 0, 8'h00, 1, 0, 1, 1, 8'hB4, 3);
        add(1, 1, 8'hC0, 1, 1, 0, 0, 8'hB5, 2);
        add(1, 0, 8'h00, 1, 0, 1, 0, 8'hB5, 0);
        // Fill to three, then reset with handshakes active.
        add(1, 1, 8'hD0, 0, 0, 1, 0, 8'hB5, 0);
        add(1, 1, 8'hD1, 0, 0, 1, 0, 8'hB5, 1);
        add(1, 1, 8'hD2, 0, 0, 1, 0, 8'hB5, 2);
        add(1, 1, 8'hD3, 0, 0, 0, 1, 8'hD0, 3);
        add(0, 1, 8'hD3, 1, 0, 1, 0, 8'h00, 0);
        add(1, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
        add(1, 1, 8'hE0, 1, 0, 1, 0, 8'h00, 0);
        add(1, 0, 8'h00, 1, 0, 1, 0, 8'h00, 1);

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset in_ready", int'(ir3), 1);
        check("reset out_valid", int'(ov3), 0);
        check("reset out_data", int'(od3), 0);
        check("reset occupancy", int'(occ3), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clock);
            #1;
            reset_n = tbl[i].rst_n;
            iv3 = tbl[i].iv; d3 = tbl[i].d; or3 = tbl[i].orr; fl3 = tbl[i].fl;
            @(negedge clock);
            check($sformatf("row%0d in_ready", i), int'(ir3), int'(tbl[i].e_ir));
            check($sformatf("row%0d out_valid", i), int'(ov3), int'(tbl[i].e_ov));
            check($sformatf("row%0d out_data", i), int'(od3), int'(tbl[i].e_od));
            check($sformatf("row%0d occupancy", i), int'(occ3), int'(tbl[i].e_occ));
        end

        // Random valid/ready traffic with scoreboards on DEPTH=1 and DEPTH=5.
        @(posedge clock);
        #1;
        iv3 = 1'b0; or3 = 1'b1; fl3 = 1'b0; reset_n = 1'b1;
        sent1 = 0; sent5 = 0; recv1 = 0; recv5 = 0; mocc1 = 0; mocc5 = 0;
        for (cyc = 0; cyc < 30000 && (recv1 < N_ITEMS || recv5 < N_ITEMS); cyc++) begin
            @(posedge clock);
            #1;
            iv1 = (sent1 < N_ITEMS) && ($urandom_range(0, 1) == 1);
            d1  = 8'($urandom);
            or1 = ($urandom_range(0, 1) == 1);
            iv5 = (sent5 < N_ITEMS) && ($urandom_range(0, 1) == 1);
            d5  = 8'($urandom);
            or5 = ($urandom_range(0, 1) == 1);
            @(negedge clock);
            acc1 = iv1 && ir1; emit1 = ov1 && or1;
            acc5 = iv5 && ir5; emit5 = ov5 && or5;
            check("d1 occupancy", int'(occ1), mocc1);
            check("d1 occupancy bound", int'(int'(occ1) <= 1), 1);
            check("d5 occupancy", int'(occ5), mocc5);
            check("d5 occupancy bound", int'(int'(occ5) <= 5), 1);
            if (emit1) begin
                if (exp_q1.size() == 0) begin
                    check("d1 unexpected output", int'(od1), -1);
                end else begin
                    e = exp_q1.pop_front();
                    check($sformatf("d1 item%0d", recv1), int'(od1), int'(e));
                end
                recv1++;
            end
            if (emit5) begin
                if (exp_q5.size() == 0) begin
                    check("d5 unexpected output", int'(od5), -1);
                end else begin
                    e = exp_q5.pop_front();
                    check($sformatf("d5 item%0d", recv5), int'(od5), int'(e));
                end
                recv5++;
            end
            if (acc1) begin exp_q1.push_back(d1); sent1++; end
            if (acc5) begin exp_q5.push_back(d5); sent5++; end
            mocc1 = mocc1 + int'(acc1) - int'(emit1);
            mocc5 = mocc5 + int'(acc5) - int'(emit5);
        end
        check("d1 items received", recv1, N_ITEMS);
        check("d5 items received", recv5, N_ITEMS);
        check("d1 queue empty", exp_q1.size(), 0);
        check("d5 queue empty", exp_q5.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
